// File: rtl/flash_stream_reader.sv
// rtl/flash_stream_reader.sv - prefetching Avalon-MM flash range reader feeding a sample-rate pop stream
// Optional: FLASH_STREAM_HALFWORD_SPLIT_EN splits each flash word into two half-width samples.
module flash_stream_reader #(
  parameter int ADDR_W      = 23,
  parameter int DATA_W      = 32,
  parameter int FIFO_DEPTH  = 8,
  parameter int MAX_PENDING = 4,
`ifdef FLASH_STREAM_HALFWORD_SPLIT_EN
  localparam int SAMPLE_W   = DATA_W / 2
`else
  localparam int SAMPLE_W   = DATA_W
`endif
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                stop,
  input  logic                dir,
  input  logic                loop_en,
  input  logic [ADDR_W-1:0]   start_addr,
  input  logic [ADDR_W-1:0]   end_addr,
  input  logic                sample_tick,
  output logic [ADDR_W-1:0]   flash_mem_address,
  output logic                flash_mem_read,
  input  logic                flash_mem_waitrequest,
  input  logic                flash_mem_readdatavalid,
  input  logic [DATA_W-1:0]   flash_mem_readdata,
  output logic [SAMPLE_W-1:0] sample_data,
  output logic                sample_valid,
  output logic                underrun,
  output logic                busy,
  output logic                done
);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int PEND_W = $clog2(MAX_PENDING + 1);
  localparam int SUM_W  = CNT_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_ABORT} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d, base_q, base_d, last_q, last_d;
  logic                dir_q, dir_d, loop_q, loop_d, single_q, single_d;
  logic [PEND_W-1:0]   pend_q, pend_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PTR_W-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [DATA_W-1:0]   fifo_mem_q [FIFO_DEPTH];
  logic [2:0]          sync_q;
  logic [SAMPLE_W-1:0] sample_q, sample_d;
  logic                valid_q, valid_d, underrun_q, underrun_d, done_q, done_d;
`ifdef FLASH_STREAM_HALFWORD_SPLIT_EN
  logic                half_q, half_d;
`endif

  logic              active, room, rd_req, accept, at_end, ret, push, pop, tick, launch;
  logic [DATA_W-1:0] head;

  assign active = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign room   = (SUM_W'(cnt_q) + SUM_W'(pend_q)) < SUM_W'(FIFO_DEPTH);
  assign rd_req = (state_q == S_RUN) && room && (pend_q < PEND_W'(MAX_PENDING));
  assign accept = rd_req && !flash_mem_waitrequest;
  assign at_end = single_q || (addr_q == last_q);
  assign ret    = flash_mem_readdatavalid && (pend_q != '0);
  assign push   = ret && active;
  assign tick   = sync_q[1] && !sync_q[2] && active && !stop;
  assign launch = (state_q == S_IDLE) && start && !stop;
  assign head   = fifo_mem_q[rd_q];

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE:  if (launch) state_d = S_RUN;
      S_RUN: begin
        if (stop) state_d = S_ABORT;
        else if (accept && at_end && (!loop_q || single_q)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (stop) state_d = S_ABORT;
        else if (pend_q == '0 && cnt_q == '0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      S_ABORT: if (pend_q == '0) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    addr_d   = addr_q;
    base_d   = base_q;
    last_d   = last_q;
    dir_d    = dir_q;
    loop_d   = loop_q;
    single_d = single_q;
    if (launch) begin
      addr_d   = start_addr;
      base_d   = start_addr;
      last_d   = end_addr;
      dir_d    = dir;
      loop_d   = loop_en;
      // An inverted range degenerates to a single read of start_addr.
      single_d = dir ? (start_addr < end_addr) : (start_addr > end_addr);
    end else if (accept) begin
      addr_d = at_end ? base_q : (dir_q ? addr_q - ADDR_W'(1) : addr_q + ADDR_W'(1));
    end

    pend_d = pend_q;
    if (accept && !ret)      pend_d = pend_q + PEND_W'(1);
    else if (!accept && ret) pend_d = pend_q - PEND_W'(1);

    pop        = 1'b0;
    valid_d    = 1'b0;
    underrun_d = 1'b0;
    sample_d   = sample_q;
`ifdef FLASH_STREAM_HALFWORD_SPLIT_EN
    half_d = half_q;
    if (tick) begin
      if (half_q) begin
        sample_d = head[DATA_W-1:SAMPLE_W];
        valid_d  = 1'b1;
        pop      = 1'b1;
        half_d   = 1'b0;
      end else if (cnt_q == '0) begin
        underrun_d = 1'b1;
      end else begin
        sample_d = head[SAMPLE_W-1:0];
        valid_d  = 1'b1;
        half_d   = 1'b1;
      end
    end
    if (launch || (active && stop)) half_d = 1'b0;
`else
    if (tick) begin
      if (cnt_q == '0) begin
        underrun_d = 1'b1;
      end else begin
        sample_d = head;
        valid_d  = 1'b1;
        pop      = 1'b1;
      end
    end
`endif

    wr_d  = push ? wr_q + PTR_W'(1) : wr_q;
    rd_d  = pop ? rd_q + PTR_W'(1) : rd_q;
    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + CNT_W'(1);
    else if (!push && pop) cnt_d = cnt_q - CNT_W'(1);
    // Leaving ABORT discards whatever was still buffered.
    if (state_q == S_ABORT && state_d == S_IDLE) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      base_q     <= '0;
      last_q     <= '0;
      dir_q      <= 1'b0;
      loop_q     <= 1'b0;
      single_q   <= 1'b0;
      pend_q     <= '0;
      cnt_q      <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      sync_q     <= '0;
      sample_q   <= '0;
      valid_q    <= 1'b0;
      underrun_q <= 1'b0;
      done_q     <= 1'b0;
`ifdef FLASH_STREAM_HALFWORD_SPLIT_EN
      half_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      base_q     <= base_d;
      last_q     <= last_d;
      dir_q      <= dir_d;
      loop_q     <= loop_d;
      single_q   <= single_d;
      pend_q     <= pend_d;
      cnt_q      <= cnt_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      sync_q     <= {sync_q[1:0], sample_tick};
      sample_q   <= sample_d;
      valid_q    <= valid_d;
      underrun_q <= underrun_d;
      done_q     <= done_d;
`ifdef FLASH_STREAM_HALFWORD_SPLIT_EN
      half_q     <= half_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_q] <= flash_mem_readdata;
  end

  assign flash_mem_address = addr_q;
  assign flash_mem_read    = rd_req;
  assign sample_data       = sample_q;
  assign sample_valid      = valid_q;
  assign underrun          = underrun_q;
  assign busy              = (state_q != S_IDLE);
  assign done              = done_q;
endmodule

// File: tb/tb_flash_stream_reader.sv
// tb/tb_flash_stream_reader.sv - scoreboard bench for flash_stream_reader with a latency-2 flash model
// Honours FLASH_STREAM_HALFWORD_SPLIT_EN by expecting two half samples per word.
module tb_flash_stream_reader;
  localparam int AW = 23;
  localparam int DW = 32;
`ifdef FLASH_STREAM_HALFWORD_SPLIT_EN
  localparam int SPW = 2;
`else
  localparam int SPW = 1;
`endif
  localparam int SW = DW / SPW;

  logic clk = 1'b0, reset_n = 1'b0;
  logic start = 1'b0, stop = 1'b0, dir = 1'b0, loop_en = 1'b0, sample_tick = 1'b0;
  logic [AW-1:0] start_addr = '0, end_addr = '0;
  logic [AW-1:0] flash_mem_address;
  logic flash_mem_read;
  logic flash_mem_waitrequest = 1'b0, flash_mem_readdatavalid = 1'b0;
  logic [DW-1:0] flash_mem_readdata = '0;
  logic [SW-1:0] sample_data;
  logic sample_valid, underrun, busy, done;

  int n_checks = 0, n_fail = 0;

  flash_stream_reader dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .dir(dir), .loop_en(loop_en),
    .start_addr(start_addr), .end_addr(end_addr), .sample_tick(sample_tick),
    .flash_mem_address(flash_mem_address), .flash_mem_read(flash_mem_read),
    .flash_mem_waitrequest(flash_mem_waitrequest), .flash_mem_readdatavalid(flash_mem_readdatavalid),
    .flash_mem_readdata(flash_mem_readdata), .sample_data(sample_data), .sample_valid(sample_valid),
    .underrun(underrun), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] fdata(input logic [AW-1:0] a);
    if (a == 23'h13) return 32'hBEEF1234;
    return {9'h150, a};
  endfunction

  logic [SW-1:0] exp_q[$];
  task automatic push_word(input logic [AW-1:0] a);
    logic [DW-1:0] w;
    w = fdata(a);
    for (int h = 0; h < SPW; h++) exp_q.push_back(SW'(w >> (h * SW)));
  endtask

  // Flash slave: accepts on read & !waitrequest, returns data two cycles later unless held.
  typedef struct { logic [AW-1:0] a; int due; } rsp_t;
  rsp_t rq[$];
  logic [AW-1:0] acc_log[$];
  int acc_cyc[$];
  int cyc = 0;
  bit hold = 0;
  int stall_idx = -1, stall_left = 0, stall_seen = 0, stall_bad = 0;
  int outst = 0, max_out = 0;
  logic [AW-1:0] stall_addr = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset_n) begin
      rq.delete();
      outst = 0;
      flash_mem_readdatavalid = 1'b0;
      flash_mem_waitrequest = 1'b0;
    end else begin
      flash_mem_readdatavalid = 1'b0;
      if (!hold && rq.size() > 0 && rq[0].due <= cyc + 1) begin
        flash_mem_readdatavalid = 1'b1;
        flash_mem_readdata = fdata(rq[0].a);
        void'(rq.pop_front());
        outst--;
      end
      flash_mem_waitrequest = 1'b0;
      if (flash_mem_read && acc_log.size() == stall_idx && stall_left > 0) begin
        flash_mem_waitrequest = 1'b1;
        stall_left--;
        if (stall_seen == 0) stall_addr = flash_mem_address;
        else if (flash_mem_address !== stall_addr) stall_bad++;
        stall_seen++;
      end
      if (flash_mem_read && !flash_mem_waitrequest) begin
        rq.push_back('{flash_mem_address, cyc + 3});
        acc_log.push_back(flash_mem_address);
        acc_cyc.push_back(cyc);
        outst++;
      end
      if (outst > max_out) max_out = outst;
    end
  end

  int done_cnt = 0, und_cnt = 0;
  always @(negedge clk) begin
    if (reset_n) begin
      if (done) done_cnt++;
      if (underrun) und_cnt++;
      if (sample_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_sample: got %0h expected none", sample_data);
        end else begin
          chk("sample_data", 64'(sample_data), 64'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_start(input logic [AW-1:0] a, input logic [AW-1:0] b, input logic d, input logic l);
    @(negedge clk);
    start_addr = a; end_addr = b; dir = d; loop_en = l; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_stop();
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      sample_tick = 1'b1; cycles(2);
      sample_tick = 1'b0; cycles(3);
    end
  endtask

  task automatic wait_idle(input string name, input int lim);
    int k;
    k = 0;
    while (busy && k < lim) begin
      @(negedge clk);
      k++;
    end
    chk(name, 64'(busy), 64'(0));
  endtask

  initial begin
    int d0, u0;
    logic [AW-1:0] exp_rev[8];
    exp_rev = '{23'h20, 23'h1F, 23'h1E, 23'h20, 23'h1F, 23'h1E, 23'h20, 23'h1F};

    cycles(3);
    reset_n = 1'b1;
    cycles(1);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_read", 64'(flash_mem_read), 64'(0));
    chk("rst_addr", 64'(flash_mem_address), 64'(0));
    chk("rst_sample", 64'(sample_data), 64'(0));
    chk("rst_flags", 64'({sample_valid, underrun, done}), 64'(0));

    // Forward 0x10..0x13, no loop
    acc_log.delete(); d0 = done_cnt;
    for (int a = 'h10; a <= 'h13; a++) push_word(AW'(a));
    do_start(23'h10, 23'h13, 1'b0, 1'b0);
    cycles(12);
    chk("t1_nreads", 64'(acc_log.size()), 64'(4));
    for (int i = 0; i < 4; i++) chk("t1_addr", 64'(acc_log[i]), 64'(23'h10 + i));
    ticks(4 * SPW);
    wait_idle("t1_idle", 50);
    chk("t1_done", 64'(done_cnt - d0), 64'(1));
    chk("t1_sb_empty", 64'(exp_q.size()), 64'(0));

    // Reverse 0x20..0x1E with loop: fill the FIFO and check wrap order
    acc_log.delete(); acc_cyc.delete(); d0 = done_cnt;
    do_start(23'h20, 23'h1E, 1'b1, 1'b1);
    cycles(16);
    chk("t2_nreads", 64'(acc_log.size()), 64'(8));
    for (int i = 0; i < 8; i++) chk("t2_addr", 64'(acc_log[i]), 64'(exp_rev[i]));
    chk("t2_nogap", 64'(acc_cyc[7] - acc_cyc[0]), 64'(7));
    do_stop();
    wait_idle("t2_idle", 20);
    chk("t2_nodone", 64'(done_cnt - d0), 64'(0));

    // Waitrequest held 5 cycles on the second read
    acc_log.delete(); d0 = done_cnt; max_out = 0;
    stall_idx = 1; stall_left = 5; stall_seen = 0; stall_bad = 0;
    for (int a = 'h40; a <= 'h4F; a++) push_word(AW'(a));
    do_start(23'h40, 23'h4F, 1'b0, 1'b0);
    cycles(30);
    chk("t3_stall_len", 64'(stall_seen), 64'(5));
    chk("t3_stall_stable", 64'(stall_bad), 64'(0));
    chk("t3_fill", 64'(acc_log.size()), 64'(8));
    chk("t3_addr1", 64'(acc_log[1]), 64'(23'h41));
    ticks(16 * SPW);
    wait_idle("t3_idle", 100);
    chk("t3_nreads", 64'(acc_log.size()), 64'(16));
    chk("t3_maxpend", 64'(max_out <= 4), 64'(1));
    chk("t3_done", 64'(done_cnt - d0), 64'(1));
    stall_idx = -1;

    // Returns withheld: underruns, sample holds, then recovery
    acc_log.delete(); d0 = done_cnt; u0 = und_cnt; hold = 1; max_out = 0;
    for (int a = 'h60; a <= 'h65; a++) push_word(AW'(a));
    do_start(23'h60, 23'h65, 1'b0, 1'b0);
    cycles(10);
    chk("t4_maxpend_reads", 64'(acc_log.size()), 64'(4));
    chk("t4_maxpend", 64'(max_out), 64'(4));
    ticks(2);
    chk("t4_underruns", 64'(und_cnt - u0), 64'(2));
    chk("t4_hold", 64'(sample_data), 64'(SW'(fdata(23'h4F) >> ((SPW - 1) * SW))));
    hold = 0;
    cycles(12);
    ticks(6 * SPW);
    wait_idle("t4_idle", 50);
    chk("t4_no_more_underrun", 64'(und_cnt - u0), 64'(2));
    chk("t4_done", 64'(done_cnt - d0), 64'(1));
    chk("t4_sb_empty", 64'(exp_q.size()), 64'(0));

    // Stop with three reads pending
    acc_log.delete(); d0 = done_cnt; u0 = und_cnt; hold = 1;
    do_start(23'h80, 23'h82, 1'b0, 1'b0);
    cycles(8);
    chk("t5_pending", 64'(outst), 64'(3));
    do_stop();
    ticks(1);
    chk("t5_abort_busy", 64'(busy), 64'(1));
    hold = 0;
    wait_idle("t5_idle", 20);
    chk("t5_noreads", 64'(acc_log.size()), 64'(3));
    chk("t5_nodone", 64'(done_cnt - d0), 64'(0));
    chk("t5_no_underrun", 64'(und_cnt - u0), 64'(0));
    d0 = done_cnt;
    push_word(23'h90); push_word(23'h91);
    do_start(23'h90, 23'h91, 1'b0, 1'b0);
    cycles(8);
    ticks(2 * SPW);
    wait_idle("t5_restart_idle", 50);
    chk("t5_restart_done", 64'(done_cnt - d0), 64'(1));
    chk("t5_sb_empty", 64'(exp_q.size()), 64'(0));

    // Asynchronous reset mid-RUN
    push_word(23'hA0);
    do_start(23'hA0, 23'hAF, 1'b0, 1'b0);
    cycles(6);
    ticks(SPW);
    cycles(1);
    #1 reset_n = 1'b0;
    #1;
    chk("t6_busy", 64'(busy), 64'(0));
    chk("t6_read", 64'(flash_mem_read), 64'(0));
    chk("t6_addr", 64'(flash_mem_address), 64'(0));
    chk("t6_sample", 64'(sample_data), 64'(0));
    chk("t6_flags", 64'({sample_valid, underrun, done}), 64'(0));
    exp_q.delete();
    cycles(2);
    reset_n = 1'b1;
    cycles(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/flash_stream_reader.md
Name: flash_stream_reader

Overview:
- Parametrised successor to the single-word flash reader: streams a contiguous flash address range into an audio sample pipeline.
- Acts as a pipelined Avalon-MM read master with multiple outstanding reads and a prefetch FIFO.
- Forward or reverse playback, optional looping; one FIFO word is popped per sample tick.
- Sits between the flash controller and the audio/sample datapath.

Parameters:
- ADDR_W, 23: flash word address width.
- DATA_W, 32: flash read data width.
- FIFO_DEPTH, 8: prefetch FIFO depth in words; power of 2, minimum 4.
- MAX_PENDING, 4: maximum outstanding reads; must be ≤ FIFO_DEPTH.

Ports:
- clk  in  1  single system clock; all logic on posedge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  1-cycle pulse; latches start_addr, end_addr, dir and loop_en, then begins streaming. Ignored unless IDLE.
- stop  in  1  1-cycle pulse; aborts streaming.
- dir  in  1  0 = forward (increment address), 1 = reverse (decrement address).
- loop_en  in  1  1 = wrap at range end, 0 = finish at range end.
- start_addr  in  ADDR_W  first word address.
- end_addr  in  ADDR_W  last word address, inclusive.
- sample_tick  in  1  asynchronous sample-rate clock; its rising edge requests one sample.
- flash_mem_address  out  ADDR_W  read address.
- flash_mem_read  out  1  read request.
- flash_mem_waitrequest  in  1  slave stall.
- flash_mem_readdatavalid  in  1  read data strobe.
- flash_mem_readdata  in  DATA_W  read data.
- sample_data  out  DATA_W  current sample (DATA_W/2 with the optional feature enabled).
- sample_valid  out  1  1-cycle pulse when sample_data has updated.
- underrun  out  1  1-cycle pulse when a tick finds the FIFO empty.
- busy  out  1  high in any state other than IDLE.
- done  out  1  1-cycle pulse on the DRAIN -> IDLE transition.

Behaviour:
- Reset values (asynchronous): all outputs 0, FIFO empty, pending count 0, state IDLE.
- States:
  - IDLE -(start)-> RUN.
  - RUN -(last address issued, loop_en = 0)-> DRAIN.
  - DRAIN -(pending = 0 and FIFO empty)-> IDLE, done pulse.
  - RUN or DRAIN -(stop)-> ABORT.
  - ABORT -(pending = 0)-> IDLE; FIFO flushed; no done pulse.
- Issue rule: in RUN, assert flash_mem_read when (FIFO count + pending) < FIFO_DEPTH and pending < MAX_PENDING.
  - Address and read are held stable while waitrequest = 1.
  - A request is accepted on a cycle with read = 1 and waitrequest = 0: pending +1, then the address steps by ±1.
- Wrap rule:
  - After an accepted read at end_addr with loop_en = 1, the next address is start_addr.
  - With loop_en = 0, read deasserts in the same cycle the request is accepted.
- Range: forward requires start_addr ≤ end_addr, reverse requires start_addr ≥ end_addr. Otherwise only start_addr is read, once.
- Return path: each readdatavalid decrements pending.
  - In RUN and DRAIN the returned word is pushed to the FIFO; in ABORT it is discarded.
  - Accept and return in the same cycle: pending is unchanged.
  - The issue rule guarantees the FIFO never overflows; readdatavalid with pending = 0 is ignored.
- Tick path: sample_tick is passed through a 2-flop synchroniser, then a rising-edge detector, giving a 3-cycle tick-to-pop latency.
  - On a detected edge with FIFO non-empty: sample_data <= head word, pop, sample_valid pulse on the following cycle.
  - On a detected edge with FIFO empty: underrun pulse; sample_data holds its value.
  - Ticks are ignored in IDLE and ABORT.
  - Push and pop in the same cycle: FIFO count is unchanged.
- stop and start in the same cycle: stop wins.

Optional Feature:
- Macro: FLASH_STREAM_HALFWORD_SPLIT_EN.
- Defined:
  - sample_data is DATA_W/2 wide.
  - Each FIFO word yields two samples, low half on the first tick, high half on the second; the word is popped on the second tick.
  - A half-select bit is cleared on start and on stop.
  - Underrun is checked only when a new word is needed.
- Undefined: one full word per tick, exactly as above.

Test Plan:
- Start 0x000010 -> 0x000013 forward, loop off, waitrequest = 0, readdatavalid 2 cycles after accept:
  - Exactly 4 reads, at 0x10, 0x11, 0x12, 0x13.
  - 4 ticks give data in address order.
  - done pulses once; busy falls.
- Reverse 0x000020 -> 0x00001E with loop on: address sequence 0x20, 0x1F, 0x1E, 0x20, 0x1F…; wrap with no gap cycle.
- Waitrequest held high 5 cycles on the 2nd read: address and read stay stable; pending never exceeds MAX_PENDING = 4; FIFO count + pending ≤ 8 throughout.
- Ticks faster than flash returns (readdatavalid withheld): underrun pulses and sample_data holds its last value; sample_valid resumes once data arrives.
- Stop issued with 3 reads pending:
  - The 3 returning words are discarded and no new reads are issued.
  - IDLE is reached after the last readdatavalid, with no done pulse.
  - A subsequent start plays correctly.
- reset_n asserted mid-RUN: all outputs go to 0 asynchronously, with no clock edge needed.
- With FLASH_STREAM_HALFWORD_SPLIT_EN, word 0xBEEF1234: ticks give 0x1234 then 0xBEEF.
